// File: rtl/sketch_trace_ctrl_if.sv
// Write port from the trace controller into the trace framebuffer.
// A word moves on any clock edge where wr_en and wr_ready are both high.
interface sketch_trace_ctrl_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 12
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/sketch_trace_ctrl.sv
// Etch-A-Sketch trace controller: turns rotary-encoder step pulses into a clamped cursor
// and sequences cell writes, including a full-screen clear sweep, into the framebuffer.
module sketch_trace_ctrl #(
  parameter int GRID_W  = 160,
  parameter int GRID_H  = 120,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 12,
  parameter int START_X = 80,
  parameter int START_Y = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_up,
  input  logic               step_down,
  input  logic               step_left,
  input  logic               step_right,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] color_in,
  sketch_trace_ctrl_if.master wr,
  output logic [X_W-1:0]     cur_x,
  output logic [Y_W-1:0]     cur_y,
  output logic               busy
);

  typedef enum logic [1:0] {CLEAR, PAINT, IDLE, WRITE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [X_W-1:0]    MAX_X     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]    MAX_Y     = Y_W'(GRID_H - 1);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  clr_addr, clr_addr_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [COLOR_W-1:0] data_q, data_n;
  logic               en_q, en_n;
  logic [X_W-1:0]     x_q, x_n, mv_x;
  logic [Y_W-1:0]     y_q, y_n, mv_y;
  // Pending step flags, packed as {right, left, down, up}.
  logic [3:0]         flags, flags_n;
  logic               clear_pend, clear_pend_n;
  logic               xfer, moved, flag_take, clear_take;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      x_q        <= X_W'(START_X);
      y_q        <= Y_W'(START_Y);
      flags      <= '0;
      clear_pend <= 1'b0;
    end else begin
      state      <= state_n;
      clr_addr   <= clr_addr_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      en_q       <= en_n;
      x_q        <= x_n;
      y_q        <= y_n;
      flags      <= flags_n;
      clear_pend <= clear_pend_n;
    end
  end

  // Opposing flags cancel; a step that would leave the grid is dropped on that axis only.
  always_comb begin
    mv_x = x_q;
    mv_y = y_q;
    if (flags[3] && !flags[2] && x_q != MAX_X)   mv_x = x_q + X_W'(1);
    else if (flags[2] && !flags[3] && x_q != '0) mv_x = x_q - X_W'(1);
    if (flags[1] && !flags[0] && y_q != MAX_Y)   mv_y = y_q + Y_W'(1);
    else if (flags[0] && !flags[1] && y_q != '0) mv_y = y_q - Y_W'(1);
    moved = (mv_x != x_q) || (mv_y != y_q);
  end

  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    addr_n     = addr_q;
    data_n     = data_q;
    en_n       = en_q;
    x_n        = x_q;
    y_n        = y_q;
    flag_take  = 1'b0;
    clear_take = 1'b0;
    xfer       = en_q && wr.wr_ready;

    case (state)
      CLEAR: begin
        // Coming out of reset the request is still idle, so raise it first.
        if (!en_q) begin
          en_n   = 1'b1;
          addr_n = clr_addr;
          data_n = '0;
        end else if (xfer) begin
          if (clear_pend) begin
            clear_take = 1'b1;
            clr_addr_n = '0;
            addr_n     = '0;
          end else if (clr_addr == LAST_ADDR) begin
            state_n = PAINT;
            addr_n  = cell_addr(x_q, y_q);
            data_n  = color_in;
          end else begin
            clr_addr_n = clr_addr + ADDR_W'(1);
            addr_n     = clr_addr + ADDR_W'(1);
          end
        end
      end
      PAINT, WRITE: begin
        if (xfer) begin
          state_n = IDLE;
          en_n    = 1'b0;
        end
      end
      IDLE: begin
        if (clear_pend) begin
          clear_take = 1'b1;
          state_n    = CLEAR;
          clr_addr_n = '0;
          en_n       = 1'b1;
          addr_n     = '0;
          data_n     = '0;
        end else if (|flags) begin
          flag_take = 1'b1;
          if (moved) begin
            state_n = WRITE;
            x_n     = mv_x;
            y_n     = mv_y;
            en_n    = 1'b1;
            addr_n  = cell_addr(mv_x, mv_y);
            data_n  = color_in;
          end
        end
      end
      default: state_n = CLEAR;
    endcase

    // Consumption clears a flag before a same-edge pulse is OR-ed back in.
    flags_n = (flag_take ? 4'b0000 : flags)
            | ((state == CLEAR) ? 4'b0000 : {step_right, step_left, step_down, step_up});
    clear_pend_n = (clear_take ? 1'b0 : clear_pend) | clear_req;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  assign wr.wr_en   = en_q;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
  assign cur_x      = x_q;
  assign cur_y      = y_q;

endmodule

// File: tb/tb_sketch_trace_ctrl.sv
// Directed bench for sketch_trace_ctrl: reset sweep, cursor moves, edge clamping,
// stalls with merged steps, clear during a write and reset during a sweep.
module tb_sketch_trace_ctrl;

  localparam int CELLS = 19200;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_up, step_down, step_left, step_right, clear_req;
  logic [11:0] color_in;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_xfer = 0;
  logic [14:0] wq_addr[$];
  logic [11:0] wq_data[$];

  sketch_trace_ctrl_if #(.ADDR_W(15), .COLOR_W(12)) wr_bus ();

  sketch_trace_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .step_up    (step_up),
    .step_down  (step_down),
    .step_left  (step_left),
    .step_right (step_right),
    .clear_req  (clear_req),
    .color_in   (color_in),
    .wr         (wr_bus),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transfer monitor: records every accepted write outside reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset === 1'b1 && wr_bus.wr_en === 1'b1 && wr_bus.wr_ready === 1'b1) begin
      wq_addr.push_back(wr_bus.wr_addr);
      wq_data.push_back(wr_bus.wr_data);
      last_xfer <= cyc;
    end
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Holds the given directions ({right,left,down,up}) and clear for exactly one edge.
  task automatic pulse(input logic [3:0] dirs, input logic clr);
    @(negedge clk);
    step_right = dirs[3];
    step_left  = dirs[2];
    step_down  = dirs[1];
    step_up    = dirs[0];
    clear_req  = clr;
    @(negedge clk);
    step_right = 1'b0;
    step_left  = 1'b0;
    step_down  = 1'b0;
    step_up    = 1'b0;
    clear_req  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int bad;
    reset = 1'b0;
    wr_bus.wr_ready = 1'b1;
    color_in = 12'hFFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || wr_bus.wr_en !== 1'b0 || wr_bus.wr_addr !== 15'd0 || wr_bus.wr_data !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: busy=%b wr_en=%b addr=%0d data=%h, want 1 0 0 0",
               busy, wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data);
    end
    n_tests++;
    if (cur_x !== 8'd80 || cur_y !== 7'd60) begin
      n_fail++;
      $display("[TB] FAIL reset_cursor: got (%0d,%0d), want (80,60)", cur_x, cur_y);
    end
    clear_log();
    reset = 1'b1;
    wait_idle(20100, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL reset_sweep_timeout: busy=%b, want 0 within 20100 cycles", busy);
    end
    n_tests++;
    if (wq_addr.size() !== CELLS + 1) begin
      n_fail++;
      $display("[TB] FAIL reset_sweep_count: got %0d writes, want %0d", wq_addr.size(), CELLS + 1);
    end
    bad = 0;
    for (int i = 0; i < CELLS && i < wq_addr.size(); i++)
      if (wq_addr[i] !== 15'(i) || wq_data[i] !== 12'h000) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_sweep_content: %0d bad clear writes, want 0", bad);
    end
    n_tests++;
    if (wq_addr.size() < CELLS + 1 || wq_addr[CELLS] !== 15'd9680 || wq_data[CELLS] !== 12'hFFF) begin
      n_fail++;
      $display("[TB] FAIL reset_paint: last write addr=%0d data=%h, want 9680 fff",
               (wq_addr.size() > 0) ? wq_addr[wq_addr.size()-1] : 15'd0,
               (wq_data.size() > 0) ? wq_data[wq_data.size()-1] : 12'd0);
    end
    n_tests++;
    if (cyc - last_xfer !== 1 || cur_x !== 8'd80 || cur_y !== 7'd60) begin
      n_fail++;
      $display("[TB] FAIL reset_busy_fall: gap=%0d cursor=(%0d,%0d), want 1 (80,60)",
               cyc - last_xfer, cur_x, cur_y);
    end
  endtask

  task automatic test_step_right();
    color_in = 12'h0A5;
    clear_log();
    pulse(4'b1000, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cur_x !== 8'd81 || wr_bus.wr_en !== 1'b1 || wr_bus.wr_addr !== 15'd9681 || wr_bus.wr_data !== 12'h0A5) begin
      n_fail++;
      $display("[TB] FAIL right_e1: x=%0d en=%b addr=%0d data=%h, want 81 1 9681 0a5",
               cur_x, wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data);
    end
    @(negedge clk);
    n_tests++;
    if (wr_bus.wr_en !== 1'b0 || busy !== 1'b0 || wq_addr.size() !== 1 || wq_addr[0] !== 15'd9681) begin
      n_fail++;
      $display("[TB] FAIL right_e2: en=%b busy=%b writes=%0d, want 0 0 1 at 9681",
               wr_bus.wr_en, busy, wq_addr.size());
    end
  endtask

  task automatic test_diagonal();
    clear_log();
    pulse(4'b1001, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cur_x !== 8'd82 || cur_y !== 7'd59 || wq_addr.size() !== 1 || wq_addr[0] !== 15'd9522) begin
      n_fail++;
      $display("[TB] FAIL diagonal: cursor=(%0d,%0d) writes=%0d, want (82,59) 1 at 9522",
               cur_x, cur_y, wq_addr.size());
    end
  endtask

  task automatic test_left_edge();
    pulse(4'b0110, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 81; i++) begin
      pulse(4'b0100, 1'b0);
      repeat (2) @(negedge clk);
    end
    n_tests++;
    if (cur_x !== 8'd0 || cur_y !== 7'd60) begin
      n_fail++;
      $display("[TB] FAIL walk_left: cursor=(%0d,%0d), want (0,60)", cur_x, cur_y);
    end
    clear_log();
    pulse(4'b0100, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cur_x !== 8'd0 || wq_addr.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL left_clamp: x=%0d writes=%0d busy=%b, want 0 0 0", cur_x, wq_addr.size(), busy);
    end
    pulse(4'b0110, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cur_x !== 8'd0 || cur_y !== 7'd61 || wq_addr.size() !== 1 || wq_addr[0] !== 15'd9760) begin
      n_fail++;
      $display("[TB] FAIL left_down_clamp: cursor=(%0d,%0d) writes=%0d, want (0,61) 1 at 9760",
               cur_x, cur_y, wq_addr.size());
    end
  endtask

  task automatic test_cancel();
    pulse(4'b1000, 1'b0);
    repeat (3) @(negedge clk);
    clear_log();
    pulse(4'b1100, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cur_x !== 8'd1 || cur_y !== 7'd61 || wq_addr.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL cancel: cursor=(%0d,%0d) writes=%0d, want (1,61) 0", cur_x, cur_y, wq_addr.size());
    end
  endtask

  task automatic test_stall();
    int bad;
    clear_log();
    wr_bus.wr_ready = 1'b0;
    pulse(4'b0010, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cur_y !== 7'd62 || wr_bus.wr_en !== 1'b1 || wr_bus.wr_addr !== 15'd9921 || wr_bus.wr_data !== 12'h0A5) begin
      n_fail++;
      $display("[TB] FAIL stall_issue: y=%0d en=%b addr=%0d data=%h, want 62 1 9921 0a5",
               cur_y, wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wr_bus.wr_en !== 1'b1 || wr_bus.wr_addr !== 15'd9921 || wr_bus.wr_data !== 12'h0A5 || cur_y !== 7'd62)
        bad++;
      step_up = (i % 2 == 0);
    end
    @(negedge clk);
    n_tests++;
    if (bad !== 0 || wq_addr.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: %0d unstable cycles, %0d writes, want 0 0", bad, wq_addr.size());
    end
    step_up = 1'b0;
    wr_bus.wr_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (wq_addr.size() !== 2 || wq_addr[0] !== 15'd9921 || wq_addr[1] !== 15'd9761 || cur_y !== 7'd61 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_merge: writes=%0d y=%0d busy=%b, want 2 (9921,9761) 61 0",
               wq_addr.size(), cur_y, busy);
    end
  endtask

  task automatic test_clear_in_write();
    bit ok;
    int bad;
    clear_log();
    wr_bus.wr_ready = 1'b0;
    pulse(4'b1000, 1'b0);
    @(negedge clk);
    pulse(4'b0000, 1'b1);
    wr_bus.wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    wait_idle(20100, ok);
    n_tests++;
    if (!ok || wq_addr.size() !== CELLS + 2) begin
      n_fail++;
      $display("[TB] FAIL clear_write_count: idle=%b writes=%0d, want 1 %0d", ok, wq_addr.size(), CELLS + 2);
    end
    bad = 0;
    for (int i = 0; i < CELLS && i + 1 < wq_addr.size(); i++)
      if (wq_addr[i+1] !== 15'(i) || wq_data[i+1] !== 12'h000) bad++;
    n_tests++;
    if (wq_addr.size() < CELLS + 2 || wq_addr[0] !== 15'd9762 || wq_data[0] !== 12'h0A5 || bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL clear_write_order: first=%0d bad_clear=%0d, want 9762 0",
               (wq_addr.size() > 0) ? wq_addr[0] : 15'd0, bad);
    end
    n_tests++;
    if (wq_addr.size() < CELLS + 2 || wq_addr[CELLS+1] !== 15'd9762 || wq_data[CELLS+1] !== 12'h0A5 ||
        cur_x !== 8'd2 || cur_y !== 7'd61) begin
      n_fail++;
      $display("[TB] FAIL clear_write_paint: cursor=(%0d,%0d), want paint at 9762 0a5 and (2,61)", cur_x, cur_y);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    bit hit;
    pulse(4'b0000, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wr_bus.wr_addr === 15'd500) begin
        hit = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("[TB] FAIL midsweep_reach: addr=%0d, want 500 within 1000 cycles", wr_bus.wr_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || wr_bus.wr_en !== 1'b0 || wr_bus.wr_addr !== 15'd0 || cur_x !== 8'd80 || cur_y !== 7'd60) begin
      n_fail++;
      $display("[TB] FAIL midsweep_reset: busy=%b en=%b addr=%0d cursor=(%0d,%0d), want 1 0 0 (80,60)",
               busy, wr_bus.wr_en, wr_bus.wr_addr, cur_x, cur_y);
    end
    clear_log();
    reset = 1'b1;
    wait_idle(20100, ok);
    n_tests++;
    if (!ok || wq_addr.size() !== CELLS + 1 || wq_addr[0] !== 15'd0 || wq_addr[CELLS] !== 15'd9680 ||
        wq_data[CELLS] !== 12'h0A5) begin
      n_fail++;
      $display("[TB] FAIL midsweep_restart: idle=%b writes=%0d, want 1 %0d from addr 0 ending at 9680",
               ok, wq_addr.size(), CELLS + 1);
    end
  endtask

  initial begin
    reset           = 1'b0;
    step_up         = 1'b0;
    step_down       = 1'b0;
    step_left       = 1'b0;
    step_right      = 1'b0;
    clear_req       = 1'b0;
    color_in        = 12'h000;
    wr_bus.wr_ready = 1'b1;
    test_reset();
    test_step_right();
    test_diagonal();
    test_left_edge();
    test_cancel();
    test_stall();
    test_clear_in_write();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
